// File: rtl/tpu_pkg.sv
// Shared types and width helpers for the convolution window scheduler.
package tpu_pkg;

    // Scheduler FSM states; also exported on the debug state port.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } sched_state_t;

    // Width of a linear image address (at least one bit).
    function automatic int calc_addr_w(input int width, input int height);
        return (width * height > 1) ? $clog2(width * height) : 1;
    endfunction

    // Width of the kernel-size field (at least one bit).
    function automatic int calc_kw(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/conv_window_scheduler_if.sv
// Job/batch bus between the host, the scheduler and the processing array.
// Handshake: a job is taken on the rising edge where cfg_valid && cfg_ready;
// cfg_ready is high only while the scheduler is idle. start is a one-cycle
// launch; the array answers with tpu_done, which only counts while waiting.
interface conv_window_scheduler_if
    import tpu_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 5,
    parameter int IMAGE_HEIGHT = 5,
    parameter int NUM_UNITS    = 9
);
    localparam int ADDR_W = calc_addr_w(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int KW     = calc_kw(IMAGE_WIDTH);

    logic                                cfg_valid;
    logic                                cfg_ready;
    logic [KW-1:0]                       kernel_dim;
    logic [1:0]                          stride;
    logic [NUM_UNITS-1:0][ADDR_W-1:0]    start_addr;
    logic [NUM_UNITS-1:0]                active_units;
    logic [2*KW-1:0]                     length;
    logic                                start;
    logic                                tpu_done;
    logic [ADDR_W-1:0]                   batch_base;
    logic                                job_done;
    logic                                cfg_err;

    // Scheduler side.
    modport master (
        input  cfg_valid, kernel_dim, stride, tpu_done,
        output cfg_ready, start_addr, active_units, length, start,
               batch_base, job_done, cfg_err
    );

    // Host / processing-array side.
    modport slave (
        output cfg_valid, kernel_dim, stride, tpu_done,
        input  cfg_ready, start_addr, active_units, length, start,
               batch_base, job_done, cfg_err
    );

endinterface

// File: rtl/conv_pos_counter.sv
// Raster walker over kernel window positions. Presents the top-left address
// of the current window and flags when it is the final window of the image.
// Row addresses accumulate IMAGE_WIDTH*S so no multiplier is needed.
module conv_pos_counter
    import tpu_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 5,
    parameter int IMAGE_HEIGHT = 5,
    parameter int ADDR_W       = 5,
    parameter int KW           = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_init,
    input  logic              i_advance,
    input  logic [KW-1:0]     i_kernel,
    input  logic [1:0]        i_stride,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    // Wide enough for col/row + S + K without wrapping.
    localparam int CW = $clog2(2 * (IMAGE_WIDTH + IMAGE_HEIGHT) + 4);
    // Row base/step carry two spare bits so a 3*W step never wraps.
    localparam int BW = ADDR_W + 2;

    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_k;
    logic [CW-1:0] r_s;
    logic [BW-1:0] r_row_base;
    logic [BW-1:0] r_row_step;
    logic [BW-1:0] w_step;
    logic          w_col_more;
    logic          w_row_more;

    // IMAGE_WIDTH*S by shift-and-add over the two stride bits.
    assign w_step = (i_stride[1] ? (BW'(IMAGE_WIDTH) << 1) : '0)
                  + (i_stride[0] ?  BW'(IMAGE_WIDTH)       : '0);

    assign w_col_more = (r_col + r_s + r_k) <= CW'(IMAGE_WIDTH);
    assign w_row_more = (r_row + r_s + r_k) <= CW'(IMAGE_HEIGHT);
    assign o_last     = !w_col_more && !w_row_more;
    assign o_addr     = ADDR_W'(r_row_base + BW'(r_col));

    // Load job geometry, then step column-first, wrapping to the next row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_k        <= '0;
            r_s        <= '0;
            r_row_base <= '0;
            r_row_step <= '0;
        end else if (i_init) begin
            r_col      <= '0;
            r_row      <= '0;
            r_k        <= CW'(i_kernel);
            r_s        <= CW'(i_stride);
            r_row_base <= '0;
            r_row_step <= w_step;
        end else if (i_advance) begin
            if (w_col_more) begin
                r_col <= r_col + r_s;
            end else if (w_row_more) begin
                r_col      <= '0;
                r_row      <= r_row + r_s;
                r_row_base <= r_row_base + r_row_step;
            end
        end
    end

endmodule

// File: rtl/conv_window_scheduler.sv
// Splits a square-kernel convolution job into batches of NUM_UNITS windows,
// fills one slot per cycle, launches the batch and waits for the array.
module conv_window_scheduler
    import tpu_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 5,
    parameter int IMAGE_HEIGHT = 5,
    parameter int NUM_UNITS    = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    conv_window_scheduler_if.master bus,
    output sched_state_t            o_state
);
    localparam int ADDR_W = calc_addr_w(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int KW     = calc_kw(IMAGE_WIDTH);
    localparam int LW     = 2 * KW;
    localparam int SW     = $clog2(NUM_UNITS + 1);

    sched_state_t                     r_state;
    sched_state_t                     w_next;
    logic                             w_cfg_ok;
    logic                             w_cfg_ready;
    logic                             w_start;
    logic                             w_job_done;
    logic                             w_job_start;
    logic                             w_advance;
    logic                             w_fill_exit;
    logic                             w_batch_next;
    logic                             w_fill_entry;
    logic [ADDR_W-1:0]                w_pos_addr;
    logic                             w_pos_last;
    logic [NUM_UNITS-1:0][ADDR_W-1:0] r_addr;
    logic [NUM_UNITS-1:0]             r_mask;
    logic [SW-1:0]                    r_slot;
    logic [LW-1:0]                    r_len;
    logic [ADDR_W-1:0]                r_base;
    logic                             r_more;
    logic                             r_cfg_err;

    // A job needs at least one window inside the image and a nonzero step.
    assign w_cfg_ok = (bus.kernel_dim != '0)
                   && (32'(bus.kernel_dim) <= 32'(IMAGE_WIDTH))
                   && (32'(bus.kernel_dim) <= 32'(IMAGE_HEIGHT))
                   && (bus.stride != 2'd0);

    // Slots are cleared whenever a fill begins, for a new job or next batch.
    assign w_fill_entry = w_job_start || w_batch_next;

    conv_pos_counter #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .ADDR_W       (ADDR_W),
        .KW           (KW)
    ) u_pos (
        .clk       (clk),
        .reset     (reset),
        .i_init    (w_job_start),
        .i_advance (w_advance),
        .i_kernel  (bus.kernel_dim),
        .i_stride  (bus.stride),
        .o_addr    (w_pos_addr),
        .o_last    (w_pos_last)
    );

    // State register; reset drops straight back to idle, abandoning any job.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-state strobes.
    always_comb begin
        w_next       = r_state;
        w_cfg_ready  = 1'b0;
        w_start      = 1'b0;
        w_job_done   = 1'b0;
        w_job_start  = 1'b0;
        w_advance    = 1'b0;
        w_fill_exit  = 1'b0;
        w_batch_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cfg_ready = 1'b1;
                if (bus.cfg_valid && w_cfg_ok) begin
                    w_job_start = 1'b1;
                    w_next      = S_FILL;
                end
            end
            S_FILL: begin
                w_fill_exit = w_pos_last || (r_slot == SW'(NUM_UNITS - 1));
                // Step past the written window unless it was the last one,
                // so a full batch leaves the walker on the next window.
                w_advance   = !w_pos_last;
                if (w_fill_exit) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_start = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                if (bus.tpu_done) begin
                    if (r_more) begin
                        w_batch_next = 1'b1;
                        w_next       = S_FILL;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_job_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Slot file, job length, batch base and the reject pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr    <= '0;
            r_mask    <= '0;
            r_slot    <= '0;
            r_len     <= '0;
            r_base    <= '0;
            r_more    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= bus.cfg_valid && w_cfg_ready && !w_cfg_ok;
            if (w_job_start) begin
                r_len  <= LW'(bus.kernel_dim) * LW'(bus.kernel_dim);
                r_base <= '0;
            end
            if (w_batch_next) begin
                r_base <= r_base + ADDR_W'(NUM_UNITS);
            end
            if (w_fill_entry) begin
                r_addr <= '0;
                r_mask <= '0;
                r_slot <= '0;
            end
            if (r_state == S_FILL) begin
                r_addr[r_slot] <= w_pos_addr;
                r_mask[r_slot] <= 1'b1;
                r_slot         <= r_slot + SW'(1);
                if (w_fill_exit) begin
                    r_more <= !w_pos_last;
                end
            end
            if (r_state == S_DONE) begin
                r_len <= '0;
            end
        end
    end

    assign bus.cfg_ready    = w_cfg_ready;
    assign bus.start        = w_start;
    assign bus.job_done     = w_job_done;
    assign bus.cfg_err      = r_cfg_err;
    assign bus.start_addr   = r_addr;
    assign bus.active_units = r_mask;
    assign bus.length       = r_len;
    assign bus.batch_base   = r_base;
    assign o_state          = r_state;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench for conv_window_scheduler on a 5x5 image, 9 units.
module tb_conv_window_scheduler;
    import tpu_pkg::*;

    localparam int IW     = 5;
    localparam int IH     = 5;
    localparam int NU     = 9;
    localparam int ADDR_W = calc_addr_w(IW, IH);
    localparam int KW     = calc_kw(IW);
    localparam int AW_ALL = ADDR_W * NU;
    localparam int EW     = AW_ALL + NU + ADDR_W;
    localparam int TMO    = 200;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    sched_state_t dbg_state;
    int           n_checks = 0;
    int           n_fail = 0;
    // Expected batches: {batch_base, active_units, start_addr}.
    logic [EW-1:0] exp_q[$];

    conv_window_scheduler_if #(.IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .NUM_UNITS(NU)) bus ();

    conv_window_scheduler #(.IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .NUM_UNITS(NU)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW_ALL-1:0] pk(input int a0, input int a1, input int a2,
                                             input int a3, input int a4, input int a5,
                                             input int a6, input int a7, input int a8);
        logic [AW_ALL-1:0] v;
        int a[9];
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        v = '0;
        for (int i = 0; i < 9; i++) v[i*ADDR_W +: ADDR_W] = ADDR_W'(a[i]);
        return v;
    endfunction

    task automatic push_const(input int base, input logic [NU-1:0] mask, input logic [AW_ALL-1:0] addrs);
        exp_q.push_back({ADDR_W'(base), mask, addrs});
    endtask

    // Reference: enumerate windows in raster order with plain arithmetic.
    task automatic push_model(input int k, input int s);
        logic [EW-1:0] e;
        int slot;
        int base;
        e = '0;
        slot = 0;
        base = 0;
        for (int r = 0; r + k <= IH; r += s) begin
            for (int c = 0; c + k <= IW; c += s) begin
                e[slot*ADDR_W +: ADDR_W] = ADDR_W'(r * IW + c);
                e[AW_ALL + slot] = 1'b1;
                slot++;
                if (slot == NU) begin
                    e[AW_ALL+NU +: ADDR_W] = ADDR_W'(base);
                    exp_q.push_back(e);
                    e = '0;
                    slot = 0;
                    base += NU;
                end
            end
        end
        if (slot != 0) begin
            e[AW_ALL+NU +: ADDR_W] = ADDR_W'(base);
            exp_q.push_back(e);
        end
    endtask

    // Drive one request for a single edge; returns #1 after the accept edge.
    task automatic send_cfg(input int k, input int s);
        bus.kernel_dim = KW'(k);
        bus.stride     = 2'(s);
        bus.cfg_valid  = 1'b1;
        check("cfg_ready_idle", 64'(bus.cfg_ready), 64'd1);
        step();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_start(output int cnt);
        cnt = 0;
        while (bus.start !== 1'b1 && cnt < TMO) begin
            step();
            bus.tpu_done = 1'b0;
            cnt++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},        64'(dbg_state),        64'(S_IDLE));
        check({tag, "_start"},        64'(bus.start),        64'd0);
        check({tag, "_job_done"},     64'(bus.job_done),     64'd0);
        check({tag, "_cfg_err"},      64'(bus.cfg_err),      64'd0);
        check({tag, "_active_units"}, 64'(bus.active_units), 64'd0);
        check({tag, "_start_addr"},   64'(bus.start_addr),   64'd0);
        check({tag, "_length"},       64'(bus.length),       64'd0);
        check({tag, "_batch_base"},   64'(bus.batch_base),   64'd0);
    endtask

    // Act as the processing array: serve every queued batch, then expect job_done.
    task automatic run_job(input int k, input bit hold_cfg, input int n_wait, input bit poke_fill);
        logic [EW-1:0]     e;
        logic [AW_ALL-1:0] s_addr;
        logic [NU-1:0]     s_mask;
        logic [ADDR_W-1:0] s_base;
        int cnt;
        bit first;
        bit stable;
        first = 1'b1;
        while (exp_q.size() > 0) begin
            wait_start(cnt);
            if (bus.start !== 1'b1) begin
                check("start_seen", 64'(bus.start), 64'd1);
                exp_q.delete();
                return;
            end
            e = exp_q.pop_front();
            // Edges from accept to the edge that samples start: slots + 1.
            if (first) check("latency", 64'(cnt + 1), 64'($countones(e[AW_ALL +: NU]) + 1));
            check("start_addr",   64'(bus.start_addr),   64'(e[AW_ALL-1:0]));
            check("active_units", 64'(bus.active_units), 64'(e[AW_ALL +: NU]));
            check("batch_base",   64'(bus.batch_base),   64'(e[AW_ALL+NU +: ADDR_W]));
            check("length",       64'(bus.length),       64'(k * k));
            s_addr = bus.start_addr;
            s_mask = bus.active_units;
            s_base = bus.batch_base;
            step();
            check("start_one_cycle", 64'(bus.start), 64'd0);
            if (hold_cfg) begin
                bus.kernel_dim = KW'(2);
                bus.stride     = 2'd1;
                bus.cfg_valid  = 1'b1;
            end
            stable = 1'b1;
            for (int i = 0; i < n_wait; i++) begin
                step();
                if (bus.start_addr !== s_addr || bus.active_units !== s_mask ||
                    bus.batch_base !== s_base || bus.start !== 1'b0 ||
                    bus.cfg_ready !== 1'b0 || bus.job_done !== 1'b0)
                    stable = 1'b0;
            end
            check("wait_stable", 64'(stable), 64'd1);
            bus.cfg_valid = 1'b0;
            bus.tpu_done  = 1'b1;
            step();
            // Optionally keep tpu_done high into the next fill cycle.
            if (!(poke_fill && exp_q.size() > 0)) bus.tpu_done = 1'b0;
            first = 1'b0;
        end
        check("job_done", 64'(bus.job_done), 64'd1);
        step();
        check("job_done_pulse", 64'(bus.job_done), 64'd0);
        check("cfg_ready_after", 64'(bus.cfg_ready), 64'd1);
    endtask

    // Watchdog.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        int cnt;
        int k;
        int s;
        int jd;
        int bad_k[3];
        int bad_s[3];
        bus.cfg_valid  = 1'b0;
        bus.kernel_dim = '0;
        bus.stride     = '0;
        bus.tpu_done   = 1'b0;
        reset          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        reset = 1'b1;
        step();
        check_reset_outputs("rst_rel");
        check("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);

        // K=3 S=1: one full batch; cfg_valid held and 20 cycles in WAIT.
        push_const(0, 9'h1FF, pk(0, 1, 2, 5, 6, 7, 10, 11, 12));
        send_cfg(3, 1);
        run_job(3, 1'b1, 20, 1'b0);

        // K=2 S=1: two batches; tpu_done poked during the second fill.
        push_const(0, 9'h1FF, pk(0, 1, 2, 3, 5, 6, 7, 8, 10));
        push_const(9, 9'h07F, pk(11, 12, 13, 15, 16, 17, 18, 0, 0));
        send_cfg(2, 1);
        run_job(2, 1'b0, 3, 1'b1);

        // K=3 S=2: partial batch, unused slots zero.
        push_const(0, 9'h00F, pk(0, 2, 10, 12, 0, 0, 0, 0, 0));
        send_cfg(3, 2);
        run_job(3, 1'b0, 2, 1'b0);

        // Rejected configurations.
        bad_k = '{0, 6, 3};
        bad_s = '{1, 1, 0};
        for (int i = 0; i < 3; i++) begin
            send_cfg(bad_k[i], bad_s[i]);
            check("cfg_err_pulse", 64'(bus.cfg_err), 64'd1);
            check("cfg_err_ready", 64'(bus.cfg_ready), 64'd1);
            check("cfg_err_nostart", 64'(bus.start), 64'd0);
            step();
            check("cfg_err_one_cycle", 64'(bus.cfg_err), 64'd0);
            check("cfg_err_idle", 64'(dbg_state), 64'(S_IDLE));
            check("cfg_err_nostart2", 64'(bus.start), 64'd0);
        end

        // Boundary kernel K = image size, then random jobs against the model.
        push_model(5, 1);
        send_cfg(5, 1);
        run_job(5, 1'b0, 1, 1'b0);
        repeat (4) begin
            k = $urandom_range(1, IW);
            s = $urandom_range(1, 3);
            push_model(k, s);
            send_cfg(k, s);
            run_job(k, 1'b0, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        // Reset in WAIT of a K=2 job: job discarded, no job_done.
        send_cfg(2, 1);
        wait_start(cnt);
        check("rst_job_start", 64'(bus.start), 64'd1);
        step();
        step();
        check("rst_in_wait", 64'(dbg_state), 64'(S_WAIT));
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_q.delete();
        step();
        reset = 1'b1;
        step();
        check("rst_mid_ready", 64'(bus.cfg_ready), 64'd1);
        bus.tpu_done = 1'b1;
        step();
        bus.tpu_done = 1'b0;
        jd = 0;
        repeat (6) begin
            if (bus.job_done !== 1'b0 || bus.start !== 1'b0) jd++;
            step();
        end
        check("rst_no_job_done", 64'(jd), 64'd0);

        // A fresh job after the aborted one.
        push_const(0, 9'h1FF, pk(0, 1, 2, 5, 6, 7, 10, 11, 12));
        send_cfg(3, 1);
        run_job(3, 1'b0, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_scheduler.md
CONV_WINDOW_SCHEDULER -- requirements
Module: conv_window_scheduler

Interface
REQ-001 Parameter: IMAGE_WIDTH, default 5, image columns.
REQ-002 Parameter: IMAGE_HEIGHT, default 5, image rows.
REQ-003 Parameter: NUM_UNITS, default 9, parallel processing units fed per batch.
REQ-004 Derived: MEM_SIZE = IMAGE_WIDTH*IMAGE_HEIGHT; ADDR_W = $clog2(MEM_SIZE); KW = $clog2(IMAGE_WIDTH).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 cfg_valid  in  1  job request.
REQ-008 cfg_ready  out  1  high only in IDLE; a job is accepted when cfg_valid && cfg_ready at a clk edge.
REQ-009 kernel_dim  in  KW  square kernel size K, sampled at accept.
REQ-010 stride  in  2  window step S, sampled at accept.
REQ-011 start_addr  out  NUM_UNITS x ADDR_W  per-unit top-left image address of its window.
REQ-012 active_units  out  NUM_UNITS  per-unit valid mask.
REQ-013 length  out  2*KW  K*K, held from accept until job end.
REQ-014 start  out  1  one-cycle batch launch pulse.
REQ-015 tpu_done  in  1  batch completion from the processing array.
REQ-016 batch_base  out  ADDR_W  linear output index of unit 0 in the current batch.
REQ-017 job_done  out  1  one-cycle pulse after the last batch completes.
REQ-018 cfg_err  out  1  one-cycle pulse on a rejected configuration.

Function
REQ-019 States: IDLE, FILL, ISSUE, WAIT, DONE.
REQ-020 Accept validity: the job SHALL be valid only if 1<=K<=IMAGE_WIDTH, K<=IMAGE_HEIGHT and S>=1.
REQ-021 Invalid job: the block SHALL pulse cfg_err the cycle after accept and SHALL stay in IDLE.
REQ-022 Window order: positions SHALL be raster order, row r = 0,S,2S..., with r+K<=IMAGE_HEIGHT; col c = 0,S,... with c+K<=IMAGE_WIDTH.
REQ-023 Address: addr = r*IMAGE_WIDTH + c, computed without multipliers by accumulating IMAGE_WIDTH*S per row step.
REQ-024 FILL: each cycle writes one slot i (0 upward), sets active_units[i]=1 and advances the position.
REQ-025 FILL SHALL exit to ISSUE after slot NUM_UNITS-1 or after the last position, whichever comes first.
REQ-026 Unused slots: on FILL entry, all slots SHALL clear to addr 0 and mask bit 0.
REQ-027 ISSUE: start=1 for exactly one cycle, then WAIT.
REQ-028 start_addr, active_units and batch_base SHALL be stable from ISSUE until tpu_done is sampled in WAIT.
REQ-029 WAIT on tpu_done=1: go to FILL if positions remain, else go to DONE.
REQ-030 tpu_done SHALL be ignored outside WAIT.
REQ-031 DONE: job_done=1 for one cycle, then IDLE.
REQ-032 cfg_valid SHALL be ignored while not IDLE.
REQ-033 batch_base SHALL increment by NUM_UNITS per completed batch and SHALL be 0 for the first batch.
REQ-034 Latency: accept edge to start high SHALL be (slots filled)+1 cycles.

Reset
REQ-035 On reset low, the block SHALL go to IDLE immediately, including mid-job.
REQ-036 Reset values: cfg_ready=1 after release; start, job_done, cfg_err=0; active_units=0; start_addr=0; length=0; batch_base=0; position counters cleared.
REQ-037 A reset while in WAIT SHALL discard the job; no job_done SHALL follow.

Structure
REQ-038 The shared package tpu_pkg SHALL hold the state enum (sched_state_t) and the ADDR_W/KW derivation functions.
REQ-039 Row/column stepping and the last-position flag SHALL live in one sub-module, conv_pos_counter, with outputs addr and last.
REQ-040 The FSM and slot registers SHALL remain in conv_window_scheduler.

Verification
REQ-041 Case K=3, S=1 on 5x5: expect one batch; addrs 0,1,2,5,6,7,10,11,12; mask 0x1FF; length 9; start 10 cycles after accept; job_done after one tpu_done.
REQ-042 Case K=2, S=1: expect two batches.
- Batch 1: addrs 0,1,2,3,5,6,7,8,10; mask 0x1FF; batch_base 0.
- Batch 2: addrs 11,12,13,15,16,17,18; mask 0x07F; batch_base 9.
REQ-043 Case K=3, S=2: expect addrs 0,2,10,12; mask 0x00F; remaining slots 0.
REQ-044 Case K=0, then K=6: expect a cfg_err pulse each time; cfg_ready stays 1; start never asserted.
REQ-045 Interference checks:
- tpu_done pulsed during FILL SHALL have no effect.
- cfg_valid held high during WAIT SHALL have no effect.
- Outputs SHALL stay stable through 20 WAIT cycles.
REQ-046 Reset asserted in WAIT of batch 1 (K=2): expect all outputs at reset values immediately; no job_done; a new K=3 job then runs correctly.
